// File: rtl/tone_sequencer_pkg.sv
// Shared audio definitions for the tone sequencer: FSM encoding, note-entry
// field positions and default oscillator constants.
package tone_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_PLAY   = 3'd3,
    ST_GAP    = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int HW_MSB  = 31;
  localparam int HW_LSB  = 12;
  localparam int DUR_MSB = 11;
  localparam int DUR_LSB = 0;

  localparam logic [19:0] HALF_WAVE_440HZ   = 20'd56_818;
  localparam logic [31:0] DEFAULT_AMPLITUDE = 32'd10_000_000;

  function automatic logic [19:0] entry_half(input logic [31:0] entry);
    return entry[HW_MSB:HW_LSB];
  endfunction

  function automatic logic [11:0] entry_dur(input logic [31:0] entry);
    return entry[DUR_MSB:DUR_LSB];
  endfunction

endpackage

// File: rtl/tone_sequencer_if.sv
// Oscillator control bundle: pitch, amplitude and phase-restart pulse.
// No handshake: the oscillator samples these every cycle; osc_restart is a
// one-cycle pulse meant to be OR'ed into the oscillator reset.
interface tone_sequencer_if;
  logic [19:0] osc_half_wavelength;
  logic [31:0] osc_amplitude;
  logic        osc_restart;

  modport master (
    output osc_half_wavelength,
    output osc_amplitude,
    output osc_restart
  );

  modport slave (
    input osc_half_wavelength,
    input osc_amplitude,
    input osc_restart
  );
endinterface

// File: rtl/tone_sequencer_ms_tick_timer.sv
// Millisecond timer: a prescaler of TICKS_PER_MS cycles driving a 12-bit
// millisecond down-counter; expire flags the last cycle of the interval.
module ms_tick_timer #(
  parameter int TICKS_PER_MS = 50_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] load_ms,
  input  logic        run,
  output logic        expire
);

  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] LAST_TICK = PW'(TICKS_PER_MS - 1);

  logic [PW-1:0] presc;
  logic [11:0]   ms_left;
  logic          wrap;

  assign wrap   = (presc == LAST_TICK);
  // Interval ends on the wrap that takes the count from 1 to 0.
  assign expire = run && wrap && (ms_left == 12'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      ms_left <= '0;
    end else if (load) begin
      presc   <= '0;
      ms_left <= load_ms;
    end else if (run) begin
      if (wrap) begin
        presc <= '0;
        if (ms_left != 12'd0) ms_left <= ms_left - 12'd1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// Melody player: walks a note table and drives the square-wave oscillator's
// pitch, amplitude and phase restart, timing each note and the gap after it.
module tone_sequencer
  import tone_sequencer_pkg::*;
#(
  parameter int          DEPTH        = 16,
  parameter int          TICKS_PER_MS = 50_000,
  parameter int          GAP_MS       = 10,
  parameter logic [31:0] AMPLITUDE    = DEFAULT_AMPLITUDE,
  localparam int         AW           = $clog2(DEPTH)
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [31:0]          wr_data,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop,
  tone_sequencer_if.master     osc,
  output logic [AW-1:0]        note_index,
  output logic                 playing,
  output logic                 done,
  output state_t               state_dbg
);

  state_t      state;
  logic [31:0] note_mem [DEPTH];
  logic [31:0] rd_data;
  logic [19:0] rd_half;
  logic [11:0] rd_dur;
  logic [19:0] half_q;
  logic [31:0] amp_q;
  logic        timer_load;
  logic        timer_expire;
  logic        at_last;
  state_t      end_state;
  state_t      adv_state;
  logic [AW-1:0] adv_index;

  // Writes only land in IDLE, so they never collide with a FETCH read.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en && state == ST_IDLE) note_mem[wr_addr] <= wr_data;
    if (state == ST_FETCH) rd_data <= note_mem[note_index];
  end

  assign rd_half   = entry_half(rd_data);
  assign rd_dur    = entry_dur(rd_data);
  assign at_last   = (note_index == AW'(DEPTH - 1));
  assign end_state = loop ? ST_FETCH : ST_DONE;
  assign adv_state = at_last ? end_state : ST_FETCH;
  assign adv_index = at_last ? (loop ? '0 : note_index) : note_index + 1'b1;

  assign timer_load = (state == ST_DECODE && rd_dur != 12'd0) ||
                      (state == ST_PLAY && timer_expire && GAP_MS > 0);

  ms_tick_timer #(
    .TICKS_PER_MS (TICKS_PER_MS)
  ) u_timer (
    .clk     (CLOCK_50),
    .rst     (reset),
    .load    (timer_load),
    .load_ms ((state == ST_DECODE) ? rd_dur : 12'(GAP_MS)),
    .run     (state == ST_PLAY || state == ST_GAP),
    .expire  (timer_expire)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      note_index <= '0;
      half_q     <= '0;
      amp_q      <= '0;
      playing    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state   <= ST_IDLE;
        amp_q   <= '0;
        playing <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            note_index <= '0;
            state      <= ST_FETCH;
            playing    <= 1'b1;
          end
          ST_FETCH: state <= ST_DECODE;
          ST_DECODE: begin
            if (rd_dur == 12'd0) begin
              state   <= end_state;
              playing <= loop;
              done    <= !loop;
              if (loop) note_index <= '0;
            end else begin
              half_q <= rd_half;
              amp_q  <= (rd_half != 20'd0) ? AMPLITUDE : '0;
              state  <= ST_PLAY;
            end
          end
          ST_PLAY: if (timer_expire) begin
            amp_q <= '0;
            if (GAP_MS > 0) begin
              state <= ST_GAP;
            end else begin
              state      <= adv_state;
              note_index <= adv_index;
              playing    <= (adv_state != ST_DONE);
              done       <= (adv_state == ST_DONE);
            end
          end
          ST_GAP: if (timer_expire) begin
            state      <= adv_state;
            note_index <= adv_index;
            playing    <= (adv_state != ST_DONE);
            done       <= (adv_state == ST_DONE);
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign osc.osc_half_wavelength = half_q;
  assign osc.osc_amplitude       = amp_q;
  assign osc.osc_restart         = (state == ST_DECODE) && (rd_dur != 12'd0);
  assign state_dbg               = state;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: two instances (GAP_MS=0 and GAP_MS=1)
// share stimulus; each scenario task checks the instance it targets.
module tb_tone_sequencer;
  import tone_sequencer_pkg::*;

  localparam logic [31:0] AMP = DEFAULT_AMPLITUDE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;

  tone_sequencer_if osc0 ();
  tone_sequencer_if osc1 ();
  logic [1:0] idx0, idx1;
  logic       pl0, pl1, dn0, dn1;
  state_t     st0, st1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    state_t      st;
    logic        rs;
    logic [19:0] half;
    logic [31:0] amp;
    logic        pl;
    logic        dn;
  } exp_t;
  exp_t trace[$];

  always #5 clk = ~clk;

  tone_sequencer #(.DEPTH(4), .TICKS_PER_MS(4), .GAP_MS(0)) u0 (
    .CLOCK_50(clk), .reset(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop(loop), .osc(osc0), .note_index(idx0),
    .playing(pl0), .done(dn0), .state_dbg(st0));

  tone_sequencer #(.DEPTH(4), .TICKS_PER_MS(4), .GAP_MS(1)) u1 (
    .CLOCK_50(clk), .reset(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop(loop), .osc(osc1), .note_index(idx1),
    .playing(pl1), .done(dn1), .state_dbg(st1));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic write_entry(input logic [1:0] a, input logic [19:0] half, input logic [11:0] dur);
    wr_en = 1'b1; wr_addr = a; wr_data = {half, dur};
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic push_seg(input int n, input state_t st, input logic rs, input logic [19:0] half,
                          input logic [31:0] amp, input logic pl, input logic dn);
    exp_t e;
    e.st = st; e.rs = rs; e.half = half; e.amp = amp; e.pl = pl; e.dn = dn;
    for (int i = 0; i < n; i++) trace.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_checks++;
    if (st0 !== ST_IDLE || osc0.osc_amplitude !== 32'd0 || osc0.osc_half_wavelength !== 20'd0 ||
        osc0.osc_restart !== 1'b0 || idx0 !== 2'd0 || pl0 !== 1'b0 || dn0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_u0: st=%0d amp=%0d half=%0d rs=%b idx=%0d pl=%b dn=%b, want all 0",
               st0, osc0.osc_amplitude, osc0.osc_half_wavelength, osc0.osc_restart, idx0, pl0, dn0);
    end
    n_checks++;
    if (st1 !== ST_IDLE || osc1.osc_amplitude !== 32'd0 || osc1.osc_half_wavelength !== 20'd0 ||
        osc1.osc_restart !== 1'b0 || idx1 !== 2'd0 || pl1 !== 1'b0 || dn1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_u1: st=%0d amp=%0d half=%0d rs=%b idx=%0d pl=%b dn=%b, want all 0",
               st1, osc1.osc_amplitude, osc1.osc_half_wavelength, osc1.osc_restart, idx1, pl1, dn1);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic load_song_table();
    write_entry(2'd0, 20'd100, 12'd2);
    write_entry(2'd1, 20'd0,   12'd1);
    write_entry(2'd2, 20'd200, 12'd3);
    write_entry(2'd3, 20'd777, 12'd0);
  endtask

  task automatic test_gap0();
    do_reset();
    load_song_table();
    trace.delete();
    push_seg(1, ST_FETCH, 0, 0, 0, 1, 0);     push_seg(1, ST_DECODE, 1, 0, 0, 1, 0);
    push_seg(8, ST_PLAY, 0, 100, AMP, 1, 0);
    push_seg(1, ST_FETCH, 0, 100, 0, 1, 0);   push_seg(1, ST_DECODE, 1, 100, 0, 1, 0);
    push_seg(4, ST_PLAY, 0, 0, 0, 1, 0);
    push_seg(1, ST_FETCH, 0, 0, 0, 1, 0);     push_seg(1, ST_DECODE, 1, 0, 0, 1, 0);
    push_seg(12, ST_PLAY, 0, 200, AMP, 1, 0);
    push_seg(1, ST_FETCH, 0, 200, 0, 1, 0);   push_seg(1, ST_DECODE, 0, 200, 0, 1, 0);
    push_seg(1, ST_DONE, 0, 200, 0, 0, 1);    push_seg(1, ST_IDLE, 0, 200, 0, 0, 0);
    pulse_start();
    for (int c = 0; c < trace.size(); c++) begin
      n_checks++;
      if (st0 !== trace[c].st || osc0.osc_restart !== trace[c].rs ||
          osc0.osc_half_wavelength !== trace[c].half || osc0.osc_amplitude !== trace[c].amp ||
          pl0 !== trace[c].pl || dn0 !== trace[c].dn) begin
        n_fail++;
        $display("FAIL gap0_cycle%0d: got st=%0d rs=%b half=%0d amp=%0d pl=%b dn=%b, want st=%0d rs=%b half=%0d amp=%0d pl=%b dn=%b",
                 c, st0, osc0.osc_restart, osc0.osc_half_wavelength, osc0.osc_amplitude, pl0, dn0,
                 trace[c].st, trace[c].rs, trace[c].half, trace[c].amp, trace[c].pl, trace[c].dn);
      end
      tick();
    end
  endtask

  task automatic test_gap1();
    do_reset();
    trace.delete();
    push_seg(1, ST_FETCH, 0, 0, 0, 1, 0);     push_seg(1, ST_DECODE, 1, 0, 0, 1, 0);
    push_seg(8, ST_PLAY, 0, 100, AMP, 1, 0);  push_seg(4, ST_GAP, 0, 100, 0, 1, 0);
    push_seg(1, ST_FETCH, 0, 100, 0, 1, 0);   push_seg(1, ST_DECODE, 1, 100, 0, 1, 0);
    push_seg(4, ST_PLAY, 0, 0, 0, 1, 0);      push_seg(4, ST_GAP, 0, 0, 0, 1, 0);
    push_seg(1, ST_FETCH, 0, 0, 0, 1, 0);     push_seg(1, ST_DECODE, 1, 0, 0, 1, 0);
    push_seg(12, ST_PLAY, 0, 200, AMP, 1, 0); push_seg(4, ST_GAP, 0, 200, 0, 1, 0);
    push_seg(1, ST_FETCH, 0, 200, 0, 1, 0);   push_seg(1, ST_DECODE, 0, 200, 0, 1, 0);
    push_seg(1, ST_DONE, 0, 200, 0, 0, 1);    push_seg(1, ST_IDLE, 0, 200, 0, 0, 0);
    pulse_start();
    for (int c = 0; c < trace.size(); c++) begin
      n_checks++;
      if (st1 !== trace[c].st || osc1.osc_restart !== trace[c].rs ||
          osc1.osc_half_wavelength !== trace[c].half || osc1.osc_amplitude !== trace[c].amp ||
          pl1 !== trace[c].pl || dn1 !== trace[c].dn) begin
        n_fail++;
        $display("FAIL gap1_cycle%0d: got st=%0d rs=%b half=%0d amp=%0d pl=%b dn=%b, want st=%0d rs=%b half=%0d amp=%0d pl=%b dn=%b",
                 c, st1, osc1.osc_restart, osc1.osc_half_wavelength, osc1.osc_amplitude, pl1, dn1,
                 trace[c].st, trace[c].rs, trace[c].half, trace[c].amp, trace[c].pl, trace[c].dn);
      end
      tick();
    end
  endtask

  task automatic test_seq_end();
    int done_at, max_idx, n_done;
    do_reset();
    write_entry(2'd0, 20'd10, 12'd1);
    write_entry(2'd1, 20'd20, 12'd1);
    write_entry(2'd2, 20'd30, 12'd1);
    write_entry(2'd3, 20'd40, 12'd1);
    loop = 1'b0;
    done_at = 0; max_idx = 0;
    pulse_start();
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      if (int'(idx0) > max_idx) max_idx = int'(idx0);
      if (dn0 === 1'b1) done_at = c;
      tick();
    end
    n_checks++;
    if (done_at != 25) begin
      n_fail++;
      $display("FAIL end_done_cycle: got %0d, want 25 (0 = no done within bound)", done_at);
    end
    n_checks++;
    if (max_idx != 3 || idx0 !== 2'd3) begin
      n_fail++;
      $display("FAIL end_index: max=%0d final=%0d, want max 3 final 3", max_idx, idx0);
    end
    n_checks++;
    if (st0 !== ST_IDLE || pl0 !== 1'b0 || dn0 !== 1'b0) begin
      n_fail++;
      $display("FAIL end_idle: st=%0d pl=%b dn=%b, want IDLE 0 0", st0, pl0, dn0);
    end
    loop = 1'b1;
    n_done = 0;
    pulse_start();
    for (int c = 1; c <= 60; c++) begin
      if (dn0 === 1'b1) n_done++;
      if (c == 25) begin
        n_checks++;
        if (st0 !== ST_FETCH || idx0 !== 2'd0 || pl0 !== 1'b1) begin
          n_fail++;
          $display("FAIL loop_refetch: st=%0d idx=%0d pl=%b, want FETCH 0 1", st0, idx0, pl0);
        end
      end
      if (c == 27) begin
        n_checks++;
        if (st0 !== ST_PLAY || osc0.osc_half_wavelength !== 20'd10 || osc0.osc_amplitude !== AMP) begin
          n_fail++;
          $display("FAIL loop_replay: st=%0d half=%0d amp=%0d, want PLAY 10 %0d",
                   st0, osc0.osc_half_wavelength, osc0.osc_amplitude, AMP);
        end
      end
      tick();
    end
    n_checks++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL loop_no_done: got %0d done pulses, want 0", n_done);
    end
    pulse_stop();
    loop = 1'b0;
  endtask

  task automatic test_stop();
    int bad;
    pulse_start();
    repeat (8) tick();
    n_checks++;
    if (st0 !== ST_PLAY || idx0 !== 2'd1 || osc0.osc_amplitude !== AMP) begin
      n_fail++;
      $display("FAIL stop_setup: st=%0d idx=%0d amp=%0d, want PLAY 1 %0d", st0, idx0, osc0.osc_amplitude, AMP);
    end
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    n_checks++;
    if (st0 !== ST_IDLE || osc0.osc_amplitude !== 32'd0 || pl0 !== 1'b0 || dn0 !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_idle: st=%0d amp=%0d pl=%b dn=%b, want IDLE 0 0 0", st0, osc0.osc_amplitude, pl0, dn0);
    end
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      if (st0 !== ST_IDLE || dn0 !== 1'b0 || pl0 !== 1'b0) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stop_stays_idle: %0d cycles left IDLE or pulsed done, want 0", bad);
    end
  endtask

  task automatic test_write_block();
    pulse_start();
    repeat (2) tick();
    n_checks++;
    if (st0 !== ST_PLAY || idx0 !== 2'd0 || osc0.osc_half_wavelength !== 20'd10) begin
      n_fail++;
      $display("FAIL wr_setup: st=%0d idx=%0d half=%0d, want PLAY 0 10", st0, idx0, osc0.osc_half_wavelength);
    end
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = {20'd999, 12'd5}; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    n_checks++;
    if (st0 !== ST_PLAY || idx0 !== 2'd0) begin
      n_fail++;
      $display("FAIL start_ignored: st=%0d idx=%0d, want PLAY 0", st0, idx0);
    end
    pulse_stop();
    pulse_start();
    repeat (2) tick();
    n_checks++;
    if (st0 !== ST_PLAY || osc0.osc_half_wavelength !== 20'd10 || osc0.osc_amplitude !== AMP) begin
      n_fail++;
      $display("FAIL wr_ignored: st=%0d half=%0d amp=%0d, want PLAY 10 %0d",
               st0, osc0.osc_half_wavelength, osc0.osc_amplitude, AMP);
    end
    pulse_stop();
  endtask

  task automatic test_async_reset();
    pulse_start();
    repeat (7) tick();
    n_checks++;
    if (st1 !== ST_GAP || osc1.osc_half_wavelength !== 20'd10 || st0 !== ST_DECODE || idx0 !== 2'd1) begin
      n_fail++;
      $display("FAIL areset_setup: u1 st=%0d half=%0d u0 st=%0d idx=%0d, want GAP 10 DECODE 1",
               st1, osc1.osc_half_wavelength, st0, idx0);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (st1 !== ST_IDLE || osc1.osc_half_wavelength !== 20'd0 || osc1.osc_amplitude !== 32'd0 || pl1 !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_u1: st=%0d half=%0d amp=%0d pl=%b, want IDLE 0 0 0",
               st1, osc1.osc_half_wavelength, osc1.osc_amplitude, pl1);
    end
    n_checks++;
    if (st0 !== ST_IDLE || idx0 !== 2'd0 || osc0.osc_restart !== 1'b0 || osc0.osc_half_wavelength !== 20'd0) begin
      n_fail++;
      $display("FAIL areset_u0: st=%0d idx=%0d rs=%b half=%0d, want IDLE 0 0 0",
               st0, idx0, osc0.osc_restart, osc0.osc_half_wavelength);
    end
    tick();
    rst = 1'b0;
    pulse_start();
    repeat (2) tick();
    n_checks++;
    if (st1 !== ST_PLAY || osc1.osc_half_wavelength !== 20'd10 || osc1.osc_amplitude !== AMP) begin
      n_fail++;
      $display("FAIL areset_table_kept: st=%0d half=%0d amp=%0d, want PLAY 10 %0d",
               st1, osc1.osc_half_wavelength, osc1.osc_amplitude, AMP);
    end
    pulse_stop();
  endtask

  initial begin
    test_reset();
    test_gap0();
    test_gap1();
    test_seq_end();
    test_stop();
    test_write_block();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Plays a stored melody on the square-wave tone oscillator by stepping through a small note table.
- Each note entry holds a half-wavelength (pitch) and a duration in milliseconds.
- For each note, the block drives the oscillator's pitch, amplitude and phase-restart inputs, times the note, inserts an optional silent gap, then advances.
- Sits between the board control logic (start/stop, table writes) and the oscillator feeding the audio codec path.

Parameters:
- DEPTH, 16: number of note-table entries (power of 2); address width AW = log2(DEPTH).
- TICKS_PER_MS, 50_000: CLOCK_50 cycles per millisecond tick.
- GAP_MS, 10: silent gap after each note, in ms; 0 means no gap.
- AMPLITUDE, 32'd10_000_000: amplitude driven during a sounding note.

Ports:
- CLOCK_50  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  note-table write strobe.
- wr_addr  input  AW  note-table write address.
- wr_data  input  32  entry: [31:12] half_wavelength, [11:0] duration_ms.
- start  input  1  begin playback at entry 0 (single-cycle pulse or level).
- stop  input  1  abort playback.
- loop  input  1  when 1, restart at entry 0 after the end of the sequence.
- osc_half_wavelength  output  20  pitch value to the oscillator.
- osc_amplitude  output  32  amplitude to the oscillator; 0 = silent.
- osc_restart  output  1  one-cycle pulse; OR'ed into the oscillator reset to realign phase.
- note_index  output  AW  index of the entry currently playing.
- playing  output  1  high in FETCH, DECODE, PLAY and GAP.
- done  output  1  one-cycle pulse at normal sequence completion.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; prescaler, duration counter and index cleared. The note table is not cleared.
- Note table:
  - DEPTH x 32 synchronous-read RAM.
  - Writes are accepted only in IDLE; wr_en in any other state is ignored.
  - Write and read of the same address never coincide, because reads occur only outside IDLE.
- States: IDLE, FETCH, DECODE, PLAY, GAP, DONE.
- IDLE:
  - Outputs silent.
  - start=1 and stop=0: set index to 0 and go to FETCH.
- FETCH: issue the table read at index. Exactly 1 cycle.
- DECODE (read data valid):
  - If duration_ms == 0 (end marker): go to DONE, or to FETCH with index 0 if loop=1.
  - Otherwise: register half_wavelength, pulse osc_restart for this cycle, clear the prescaler, load the duration counter, go to PLAY.
- PLAY:
  - osc_amplitude = AMPLITUDE when half_wavelength != 0; 0 otherwise (rest note).
  - The prescaler counts 0..TICKS_PER_MS-1; on each wrap the duration counter decrements.
  - When the counter reaches 0 at a wrap, go to GAP (GAP_MS > 0) or advance (GAP_MS = 0).
  - PLAY lasts exactly duration_ms * TICKS_PER_MS cycles.
- GAP:
  - osc_amplitude = 0; half_wavelength holds.
  - Lasts exactly GAP_MS * TICKS_PER_MS cycles, then advance.
- Advance:
  - If index == DEPTH-1: treat as end of sequence (loop or DONE).
  - Otherwise: index+1, go to FETCH. Index never wraps silently.
- DONE: done=1 for one cycle, outputs silent, go to IDLE.
- Latency:
  - start sampled at edge N gives FETCH after N, DECODE after N+1, and PLAY with amplitude valid after N+2.
  - osc_restart is high during the DECODE cycle.
  - Between consecutive notes with GAP_MS=0 there are 2 silent cycles (FETCH and DECODE); amplitude is forced to 0 there.
- Control interactions:
  - stop=1 in any state goes to IDLE at the next edge with no done pulse; amplitude is 0 from that edge.
  - stop has priority over start.
  - start outside IDLE is ignored.
  - loop is sampled at the end-of-sequence decision only.
- Counter widths:
  - Prescaler: clog2(TICKS_PER_MS) bits.
  - Duration counter: 12 bits; the maximum note is 4095 ms.

Decomposition:
- Shared audio package holds:
  - state encoding;
  - field positions HW_MSB=31, HW_LSB=12, DUR_MSB=11, DUR_LSB=0;
  - the 440 Hz half-wavelength constant, 20'd56_818;
  - the default AMPLITUDE.
- One natural sub-module: ms_tick_timer, containing the prescaler plus the down-counter with load/clear and an expire flag. It is reused for both PLAY and GAP.

Test Plan (TICKS_PER_MS=4, DEPTH=4 unless stated):
- GAP_MS=0; table {(100,2),(0,1),(200,3),(x,0)}; start → osc_restart in DECODE; half=100 with amplitude for 8 cycles; 2 silent cycles; rest for 4 cycles with amplitude 0; then half=200 for 12 cycles; then done pulse and playing=0.
- GAP_MS=1, same table → each note is followed by exactly 4 cycles with amplitude 0 before the next FETCH.
- All 4 entries nonzero, loop=0 → after entry 3 a done pulse with index never exceeding 3. With loop=1 → entry 0 re-fetched, no done pulse.
- stop asserted mid-PLAY of entry 1 → next edge IDLE, amplitude 0, no done pulse. A start in the same cycle as stop has no effect.
- wr_en during PLAY targeting the current entry → table unchanged; readback after IDLE shows the old value. start during PLAY is ignored (index unchanged).
- reset asserted asynchronously mid-GAP → outputs 0 immediately, without waiting for a clock edge. After release, start replays the table, which still holds its contents.
